// File: rtl/time_set_keeper.sv
// 24-hour BCD time-of-day keeper with debounced MODE/INC buttons for field editing.
// Optional field blinking is compiled in with `define TIME_BLINK_EN.
module time_set_keeper #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [2:0] edit_sel,
  output logic [2:0] blank,
  output logic       sec_tick
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DebMax   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StSetHour, StSetMin, StSetSec} state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // Key path: index 0 = MODE, index 1 = INC.
  logic [1:0]         key_raw;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         stable_q, stable_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]         press;
  logic               mode_ev, inc_ev;

  assign key_raw = {key_inc, key_mode};

  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    press     = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] == stable_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DebMax) begin
        deb_cnt_d[k] = '0;
        stable_d[k]  = sync2_q[k];
        press[k]     = ~sync2_q[k];
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
      end
    end
  end

  assign mode_ev = press[0];
  assign inc_ev  = press[1];

  // Time keeping and edit FSM
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [2:0]    edit_sel_q, edit_sel_d;
  logic          tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;

    if (state_q == StRun) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
        sec_d   = bcd_inc(sec_q, 8'h59);
        if (sec_q == 8'h59) begin
          min_d = bcd_inc(min_q, 8'h59);
          if (min_q == 8'h59) begin
            hour_d = bcd_inc(hour_q, 8'h23);
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
    end

    // MODE beats a coincident INC; the RUN time advance above still applies.
    if (mode_ev) begin
      unique case (state_q)
        StRun:     state_d = StSetHour;
        StSetHour: state_d = StSetMin;
        StSetMin:  state_d = StSetSec;
        StSetSec:  state_d = StRun;
      endcase
    end else if (inc_ev) begin
      unique case (state_q)
        StRun:     ;
        StSetHour: hour_d = bcd_inc(hour_q, 8'h23);
        StSetMin:  min_d  = bcd_inc(min_q, 8'h59);
        StSetSec:  sec_d  = bcd_inc(sec_q, 8'h59);
      endcase
    end

    unique case (state_d)
      StRun:     edit_sel_d = 3'b000;
      StSetHour: edit_sel_d = 3'b100;
      StSetMin:  edit_sel_d = 3'b010;
      StSetSec:  edit_sel_d = 3'b001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      stable_q   <= 2'b11;
      deb_cnt_q  <= '0;
      state_q    <= StRun;
      presc_q    <= '0;
      hour_q     <= 8'h00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      edit_sel_q <= 3'b000;
      tick_q     <= 1'b0;
    end else begin
      sync1_q    <= key_raw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      edit_sel_q <= edit_sel_d;
      tick_q     <= tick_d;
    end
  end

`ifdef TIME_BLINK_EN
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BlinkMax = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Restart on INC so a freshly edited field is shown immediately.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if ((state_q == StRun) || (state_d == StRun) || inc_ev) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank = phase_q ? edit_sel_q : 3'b000;
`else
  logic unused_blink_half;
  assign unused_blink_half = ^BLINK_HALF;
  assign blank = 3'b000;
`endif

  assign hours    = hour_q;
  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign edit_sel = edit_sel_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_time_set_keeper.sv
// Randomized bench for time_set_keeper against a seconds/fields reference model.
// Build with +define+TIME_BLINK_EN to also check blinking.
module tb_time_set_keeper;

  localparam int unsigned CF  = 10;
  localparam int unsigned DEB = 4;
  localparam int unsigned BH  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b1;
  logic       key_inc = 1'b1;
  logic [7:0] hours, minutes, seconds;
  logic [2:0] edit_sel, blank;
  logic       sec_tick;

  time_set_keeper #(
    .CLK_FREQ  (CF),
    .DEB_CYCLES(DEB),
    .BLINK_HALF(BH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_mode(key_mode),
    .key_inc (key_inc),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds),
    .edit_sel(edit_sel),
    .blank   (blank),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tick_cnt = 0;

  // Reference model: mode 0=RUN 1=hour 2=min 3=sec, plain integer fields.
  int st = 0, hh = 0, mm = 0, ss = 0, pc = 0, bt = 0;
  bit tick_m = 1'b0;
  int mode_q[$];
  int inc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [2:0] sel_of(input int s);
    case (s)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_edge();
    bit mev = 1'b0;
    bit iev = 1'b0;
    int old;
    while (mode_q.size() > 0 && mode_q[0] <= cyc) begin
      if (mode_q[0] == cyc) mev = 1'b1;
      void'(mode_q.pop_front());
    end
    while (inc_q.size() > 0 && inc_q[0] <= cyc) begin
      if (inc_q[0] == cyc) iev = 1'b1;
      void'(inc_q.pop_front());
    end
    tick_m = 1'b0;
    if (rst) begin
      st = 0; hh = 0; mm = 0; ss = 0; pc = 0; bt = 0;
      mode_q.delete();
      inc_q.delete();
    end else begin
      if (st == 0) begin
        if (pc == CF - 1) begin
          pc = 0;
          tick_m = 1'b1;
          ss++;
          if (ss == 60) begin
            ss = 0;
            mm++;
            if (mm == 60) begin
              mm = 0;
              hh = (hh + 1) % 24;
            end
          end
        end else begin
          pc++;
        end
      end else begin
        pc = 0;
      end
      old = st;
      if (mev) st = (st + 1) % 4;
      else if (iev) begin
        case (old)
          1: hh = (hh + 1) % 24;
          2: mm = (mm + 1) % 60;
          3: ss = (ss + 1) % 60;
          default: ;
        endcase
      end
      if (st == 0 || old == 0 || iev) bt = 0;
      else bt++;
    end
  endtask

  task automatic step();
    logic [2:0]  exp_blank;
    logic [31:0] got_v, exp_v;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
`ifdef TIME_BLINK_EN
    exp_blank = (((bt / BH) % 2) == 1) ? sel_of(st) : 3'b000;
`else
    exp_blank = 3'b000;
`endif
    got_v = {1'b0, hours, minutes, seconds, edit_sel, blank, sec_tick};
    exp_v = {1'b0, bcd(hh), bcd(mm), bcd(ss), sel_of(st), exp_blank, tick_m};
    check_eq("outputs", got_v, exp_v);
    if (sec_tick) tick_cnt++;
  endtask

  // Key held low for len cycles; accepted only if len >= DEB, 2+DEB edges after the fall.
  task automatic press(input bit pm, input bit pi, input int len, input int gap);
    if (pm) begin
      key_mode = 1'b0;
      if (len >= DEB) mode_q.push_back(cyc + 2 + DEB);
    end
    if (pi) begin
      key_inc = 1'b0;
      if (len >= DEB) inc_q.push_back(cyc + 2 + DEB);
    end
    repeat (len) step();
    key_mode = 1'b1;
    key_inc  = 1'b1;
    repeat (gap) step();
  endtask

  task automatic inc_n(input int n);
    repeat (n) press(1'b0, 1'b1, DEB + $urandom_range(0, 2), DEB + 2 + $urandom_range(0, 2));
  endtask

  initial begin
    logic [7:0] min_exp[3];
    logic [7:0] sec_keep;
    int w;
    int r;
    min_exp[0] = 8'h59;
    min_exp[1] = 8'h00;
    min_exp[2] = 8'h01;

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check_eq("reset_out", 32'({hours, minutes, seconds, edit_sel, blank, sec_tick}), 32'd0);

    // Free run: one minute of ticks.
    tick_cnt = 0;
    repeat (600) step();
    check_eq("ticks600", 32'(tick_cnt), 32'd60);
    check_eq("time600", 32'({hours, minutes, seconds}), 32'h000100);

    // Debounce: short glitch ignored, long press accepted at 6 cycles, hold gives one event.
    press(1'b1, 1'b0, 3, 8);
    check_eq("glitch_sel", 32'(edit_sel), 32'd0);
    key_mode = 1'b0;
    mode_q.push_back(cyc + 2 + DEB);
    repeat (5) step();
    check_eq("deb_early", 32'(edit_sel), 32'd0);
    step();
    check_eq("deb_edge", 32'(edit_sel), 32'b100);
    repeat (10) step();
    check_eq("deb_hold", 32'(edit_sel), 32'b100);
    key_mode = 1'b1;
    repeat (8) step();
    check_eq("deb_release", 32'(edit_sel), 32'b100);

    // Edit to 23:59:59, with the minute wrap checked on the way.
    inc_n((23 - hh + 24) % 24);
    check_eq("set_hour", 32'(hours), 32'h23);
    press(1'b1, 1'b0, DEB, DEB + 2);
    check_eq("sel_min", 32'(edit_sel), 32'b010);
    inc_n((58 - mm + 60) % 60);
    check_eq("set_min58", 32'(minutes), 32'h58);
    sec_keep = bcd(ss);
    tick_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1, DEB, DEB + 2);
      check_eq("edit_min", 32'(minutes), 32'(min_exp[i]));
      check_eq("edit_hour_keep", 32'(hours), 32'h23);
      check_eq("edit_sec_keep", 32'(seconds), 32'(sec_keep));
    end
    check_eq("edit_no_tick", 32'(tick_cnt), 32'd0);
    inc_n(58);
    press(1'b1, 1'b0, DEB, DEB + 2);
    inc_n((59 - ss + 60) % 60);
    check_eq("set_235959", 32'({hours, minutes, seconds}), 32'h235959);
    press(1'b1, 1'b0, DEB, DEB + 2);
    check_eq("back_run", 32'(edit_sel), 32'd0);
    w = 0;
    while (!sec_tick && w < 30) begin
      step();
      w++;
    end
    check_eq("roll_tick", 32'(sec_tick), 32'd1);
    check_eq("roll_lat", 32'(w), 32'd6);
    check_eq("roll_time", 32'({hours, minutes, seconds}), 32'h000000);

    // Simultaneous MODE+INC in SET_HOUR, then reset mid-edit.
    press(1'b1, 1'b0, DEB, DEB + 2);
    press(1'b1, 1'b1, DEB, DEB + 2);
    check_eq("simul_sel", 32'(edit_sel), 32'b010);
    check_eq("simul_hour", 32'(hours), 32'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_edit", 32'({hours, minutes, seconds, edit_sel}), 32'd0);

    // Linger in SET_HOUR so blinking (or its absence) is exercised, with an INC inside.
    press(1'b1, 1'b0, DEB, 20);
    press(1'b0, 1'b1, DEB, 20);
    repeat (3) press(1'b1, 1'b0, DEB, DEB + 2);

    // Random key traffic.
    repeat (250) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        repeat ($urandom_range(1, 25)) step();
      end else if (r < 55) begin
        press(1'b1, 1'b0, $urandom_range(1, 8), $urandom_range(DEB + 2, DEB + 6));
      end else if (r < 85) begin
        press(1'b0, 1'b1, $urandom_range(1, 8), $urandom_range(DEB + 2, DEB + 6));
      end else if (r < 93) begin
        press(1'b1, 1'b1, $urandom_range(1, 8), $urandom_range(DEB + 2, DEB + 6));
      end else if (r < 97) begin
        press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(1, DEB - 1), $urandom_range(DEB + 2, DEB + 6));
      end else begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
